// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter
//   Shares the single read/write port of a 32 x 16-bit register file between
//   requester 0 (fetch/decode) and requester 1 (writeback/debug). Each access
//   is a 3-cycle IDLE -> ACCESS -> DONE transaction with a one-cycle Gnt
//   pulse in ACCESS and a one-cycle Done pulse in DONE. Simultaneous requests
//   are resolved round-robin.
//
//   Optional macro RFARB_FIXED_PRIORITY_EN: requester 0 always wins a tie.
//   The pointer is then held at 0.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   Req/Wr/Addr/WData0,1 request, write flag, address, write data per requester
//   Gnt0/1, Done0/1      grant and completion pulses to the winner
//   RData                read data, valid during Done after a read
//   RfAddr, RfWriteEn,
//   RfWriteData          register file control (address shared by read/write)
//   RfReadValue          combinational read value from the register file
//   Busy                 high whenever a transaction is in flight
module regfile_access_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic                  Wr0,
  input  logic                  Wr1,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WData0,
  input  logic [DATA_WIDTH-1:0] WData1,
  output logic                  Gnt0,
  output logic                  Gnt1,
  output logic                  Done0,
  output logic                  Done1,
  output logic [DATA_WIDTH-1:0] RData,
  output logic [ADDR_WIDTH-1:0] RfAddr,
  output logic                  RfWriteEn,
  output logic [DATA_WIDTH-1:0] RfWriteData,
  input  logic [DATA_WIDTH-1:0] RfReadValue,
  output logic                  Busy
);

`ifdef RFARB_FIXED_PRIORITY_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t state, state_nxt;
  logic   ptr, ptr_nxt;
  logic   win_id, win_wr;
  logic   take, pick;
  req_t   req0, req1, sel;

  logic [DATA_WIDTH-1:0] rdata_q, wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  assign req0 = '{wr: Wr0, addr: Addr0, wdata: WData0};
  assign req1 = '{wr: Wr1, addr: Addr1, wdata: WData1};
  assign sel  = pick ? req1 : req0;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    take      = 1'b0;
    pick      = 1'b0;
    Gnt0      = 1'b0;
    Gnt1      = 1'b0;
    Done0     = 1'b0;
    Done1     = 1'b0;
    RfWriteEn = 1'b0;
    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          take      = 1'b1;
          state_nxt = ACCESS;
          // tie goes to the pointer (or always to 0 in fixed-priority builds)
          pick      = (Req0 && Req1) ? (ptr & ~FIXED_PRIO) : Req1;
        end
      end
      ACCESS: begin
        state_nxt = DONE;
        Gnt0      = ~win_id;
        Gnt1      = win_id;
        RfWriteEn = win_wr;
      end
      DONE: begin
        state_nxt = IDLE;
        Done0     = ~win_id;
        Done1     = win_id;
        ptr_nxt   = FIXED_PRIO ? 1'b0 : ~win_id;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      win_id  <= 1'b0;
      win_wr  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      // address/data are loaded at acceptance so they are already stable
      // through ACCESS and simply hold afterwards
      if (take) begin
        win_id <= pick;
        win_wr <= sel.wr;
        addr_q <= sel.addr;
        if (sel.wr) wdata_q <= sel.wdata;
      end
      if (state == ACCESS && !win_wr) rdata_q <= RfReadValue;
    end
  end

  assign RData       = rdata_q;
  assign RfAddr      = addr_q;
  assign RfWriteData = wdata_q;
  assign Busy        = (state != IDLE);

endmodule

// File: tb/tb_regfile_access_arbiter.sv
module tb_regfile_access_arbiter;
  localparam int DW = 16;
  localparam int AW = 5;

`ifdef RFARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk, reset;
  logic Req0, Req1, Wr0, Wr1;
  logic [AW-1:0] Addr0, Addr1, RfAddr;
  logic [DW-1:0] WData0, WData1, RData, RfWriteData, RfReadValue;
  logic Gnt0, Gnt1, Done0, Done1, RfWriteEn, Busy;

  regfile_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .RData(RData), .RfAddr(RfAddr), .RfWriteEn(RfWriteEn),
    .RfWriteData(RfWriteData), .RfReadValue(RfReadValue), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file environment
  logic [DW-1:0] rf [32];
  assign RfReadValue = rf[RfAddr];
  always @(posedge clk) if (RfWriteEn) rf[RfAddr] <= RfWriteData;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: a transaction accepted at edge s occupies cycles
  // s (grant) and s+1 (done); the next acceptance is possible at edge s+3
  int            cyc = 0;
  bit            m_act = 0, m_ptr = 0, m_id = 0, m_wr = 0;
  int            m_start = -10, m_free = 0;
  logic [AW-1:0] m_addr = '0, m_rfaddr = '0;
  logic [DW-1:0] m_data = '0, m_rdata = '0, m_wdata = '0;
  logic [DW-1:0] mem [32];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      // a strobe already on the port during the reset cycle still lands
      if (m_act && cyc == m_start + 1 && m_wr) mem[m_addr] = m_data;
      m_act = 0; m_ptr = 0; m_free = cyc + 1;
      m_rdata = '0; m_rfaddr = '0; m_wdata = '0;
    end else begin
      if (m_act && cyc == m_start + 1) begin
        if (m_wr) mem[m_addr] = m_data;
        else      m_rdata = mem[m_addr];
      end
      if (m_act && cyc == m_start + 2) begin
        m_ptr = FIXED ? 1'b0 : !m_id;
        m_act = 0;
      end
      if (cyc >= m_free && (Req0 || Req1)) begin
        m_id   = (Req0 && Req1) ? m_ptr : Req1;
        m_wr   = m_id ? Wr1 : Wr0;
        m_addr = m_id ? Addr1 : Addr0;
        m_data = m_id ? WData1 : WData0;
        m_act = 1; m_start = cyc; m_free = cyc + 3;
        m_rfaddr = m_addr;
        if (m_wr) m_wdata = m_data;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      bit g, d;
      g = m_act && cyc == m_start;
      d = m_act && cyc == m_start + 1;
      chk("Gnt0", Gnt0, g && !m_id);
      chk("Gnt1", Gnt1, g && m_id);
      chk("Done0", Done0, d && !m_id);
      chk("Done1", Done1, d && m_id);
      chk("RfWriteEn", RfWriteEn, g && m_wr);
      chk("Busy", Busy, m_act);
      chk("RData", RData, m_rdata);
      chk("RfAddr", RfAddr, m_rfaddr);
      chk("RfWriteData", RfWriteData, m_wdata);
      chk("GntExcl", Gnt0 & Gnt1, 0);
      chk("DoneExcl", Done0 & Done1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    Req0 = 0; Req1 = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i]  = DW'(i);
      mem[i] = DW'(i);
    end
    reset = 1; Req0 = 0; Req1 = 0; Wr0 = 0; Wr1 = 0;
    Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;
    tick();
    chk_en = 1;
    chk("rst_busy", Busy, 0);
    chk("rst_rdata", RData, 0);
    chk("rst_rfaddr", RfAddr, 0);
    tick();
    reset = 0;

    // 1: read reg3
    Req0 = 1; Wr0 = 0; Addr0 = 5'd3;
    tick();
    chk("t1_gnt0", Gnt0, 1);
    chk("t1_gnt1", Gnt1, 0);
    Req0 = 0;
    tick();
    chk("t1_done0", Done0, 1);
    chk("t1_rdata", RData, 16'h0003);
    chk("t1_done1", Done1, 0);
    tick();
    chk("t1_idle", Busy, 0);

    // 2: write reg7 = BEEF from requester 1, then read it back via 0
    Req1 = 1; Wr1 = 1; Addr1 = 5'd7; WData1 = 16'hBEEF;
    tick();
    chk("t2_wen", RfWriteEn, 1);
    chk("t2_addr", RfAddr, 7);
    chk("t2_wdata", RfWriteData, 16'hBEEF);
    Req1 = 0;
    tick();
    chk("t2_wen_off", RfWriteEn, 0);
    chk("t2_done1", Done1, 1);
    tick();
    Req0 = 1; Wr0 = 0; Addr0 = 5'd7;
    tick();
    Req0 = 0;
    tick();
    chk("t2_rdata", RData, 16'hBEEF);
    tick();

    // 3: both held for 8 transactions from reset
    reset = 1;
    tick();
    reset = 0;
    Req0 = 1; Req1 = 1; Wr0 = 0; Wr1 = 0; Addr0 = 5'd1; Addr1 = 5'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_gnt0", Gnt0, FIXED ? 1 : (i % 2 == 0));
      chk("t3_gnt1", Gnt1, FIXED ? 0 : (i % 2 == 1));
      tick();
      tick();
      chk("t3_gap", Busy, 0);
      if (i == 7) idle_reqs();
    end
    tick();

    // 4: one-cycle pulse on Req0 still completes
    Req0 = 1; Wr0 = 0; Addr0 = 5'd5;
    tick();
    Req0 = 0;
    chk("t4_gnt0", Gnt0, 1);
    tick();
    chk("t4_done0", Done0, 1);
    chk("t4_rdata", RData, 16'h0005);
    tick();

    // 5: reset during a requester-1 write in ACCESS
    Req1 = 1; Wr1 = 1; Addr1 = 5'd9; WData1 = 16'h1234;
    tick();
    chk("t5_gnt1", Gnt1, 1);
    Req1 = 0; reset = 1;
    tick();
    reset = 0;
    chk("t5_busy", Busy, 0);
    chk("t5_done1", Done1, 0);
    chk("t5_wen", RfWriteEn, 0);
    Req0 = 1; Req1 = 1; Wr0 = 0; Wr1 = 0; Addr0 = 5'd4; Addr1 = 5'd6;
    tick();
    chk("t5_gnt0_after_rst", Gnt0, 1);
    idle_reqs();
    tick();
    tick();

    // random traffic; requesters hold until granted
    for (int n = 0; n < 900; n++) begin
      tick();
      reset = ($urandom_range(0, 99) == 0);
      if (Gnt0 || !Req0) begin
        Req0 = Gnt0 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
        Wr0 = $urandom_range(0, 1) == 1; Addr0 = AW'($urandom_range(0, 31)); WData0 = DW'($urandom);
      end
      if (Gnt1 || !Req1) begin
        Req1 = Gnt1 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
        Wr1 = $urandom_range(0, 1) == 1; Addr1 = AW'($urandom_range(0, 31)); WData1 = DW'($urandom);
      end
    end
    reset = 0;
    idle_reqs();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
